// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC, IF/ID register, stall/flush counters
module if_stage_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != {CNT_WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end
endmodule

module if_stage #(
    parameter int                     PC_WIDTH    = 8,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = '0,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             MUX_IF_PM,
    input  logic                   Is_Address_Taken,
    input  logic [PC_WIDTH-1:0]    Branch_Target,
    output logic [PC_WIDTH-1:0]    Instr_Mem_Addr,
    input  logic [INSTR_WIDTH-1:0] Instr_Mem_Data,
    output logic [INSTR_WIDTH-1:0] Instr_ID,
    output logic [PC_WIDTH-1:0]    PC_ID,
    output logic                   Valid_ID,
    output logic [CNT_WIDTH-1:0]   Stall_Count,
    output logic [CNT_WIDTH-1:0]   Flush_Count
);
    logic [PC_WIDTH-1:0] pc_q;
    logic                freeze;
    logic                flush;

    // Encoding 11 is folded into freeze, so bit 1 alone marks a hold.
    assign freeze = MUX_IF_PM[1];
    assign flush  = (MUX_IF_PM == 2'b01);

    assign Instr_Mem_Addr = pc_q;

    // A redirect overrides freeze; the hazard unit pairs it with a flush anyway.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (Is_Address_Taken) begin
            pc_q <= Branch_Target;
        end else if (!freeze) begin
            pc_q <= pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            Instr_ID <= NOP_INSTR;
            PC_ID    <= '0;
            Valid_ID <= 1'b0;
        end else if (!freeze) begin
            Instr_ID <= Instr_Mem_Data;
            PC_ID    <= pc_q;
            Valid_ID <= 1'b1;
        end
    end

    if_stage_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze),
        .count (Stall_Count)
    );

    if_stage_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush),
        .count (Flush_Count)
    );
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage
module tb_if_stage;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  mux;
    logic        taken;
    logic [7:0]  target;
    logic [7:0]  addr;
    logic [31:0] mem_data;
    logic [31:0] instr_id;
    logic [7:0]  pc_id;
    logic        valid_id;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    logic        rst2;
    logic [1:0]  mux2;
    logic [7:0]  addr2;
    logic [31:0] mem_data2;
    logic [31:0] instr_id2;
    logic [7:0]  pc_id2;
    logic        valid_id2;
    logic [3:0]  stall_cnt2;
    logic [3:0]  flush_cnt2;

    // mem[i] = 32'h100 + i
    assign mem_data  = 32'h100 + {24'h0, addr};
    assign mem_data2 = 32'h100 + {24'h0, addr2};

    if_stage dut (
        .clk              (clk),
        .rst              (rst),
        .MUX_IF_PM        (mux),
        .Is_Address_Taken (taken),
        .Branch_Target    (target),
        .Instr_Mem_Addr   (addr),
        .Instr_Mem_Data   (mem_data),
        .Instr_ID         (instr_id),
        .PC_ID            (pc_id),
        .Valid_ID         (valid_id),
        .Stall_Count      (stall_cnt),
        .Flush_Count      (flush_cnt)
    );

    if_stage #(.CNT_WIDTH(4)) dut_sat (
        .clk              (clk),
        .rst              (rst2),
        .MUX_IF_PM        (mux2),
        .Is_Address_Taken (1'b0),
        .Branch_Target    (8'h00),
        .Instr_Mem_Addr   (addr2),
        .Instr_Mem_Data   (mem_data2),
        .Instr_ID         (instr_id2),
        .PC_ID            (pc_id2),
        .Valid_ID         (valid_id2),
        .Stall_Count      (stall_cnt2),
        .Flush_Count      (flush_cnt2)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  mux;
        logic        taken;
        logic [7:0]  target;
        logic [7:0]  exp_addr;
        logic [31:0] exp_instr;
        logic [7:0]  exp_pc_id;
        logic        exp_valid;
        logic [15:0] exp_stall;
        logic [15:0] exp_flush;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic add(input logic r, input logic [1:0] m, input logic t, input logic [7:0] tg,
                       input logic [7:0] ea, input logic [31:0] ei, input logic [7:0] ep,
                       input logic ev, input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.rst = r; v.mux = m; v.taken = t; v.target = tg;
        v.exp_addr = ea; v.exp_instr = ei; v.exp_pc_id = ep;
        v.exp_valid = ev; v.exp_stall = es; v.exp_flush = ef;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1; mux = 2'b00; taken = 1'b0; target = 8'h00;
        rst2 = 1'b1; mux2 = 2'b00;

        //   rst mux    tk  tgt    addr   instr      pc_id  v  stall flush
        add(1, 2'b00, 0, 8'h00, 8'h00, 32'h0,     8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h01, 32'h100,   8'h00, 1, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h02, 32'h101,   8'h01, 1, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h03, 32'h102,   8'h02, 1, 0, 0);
        add(0, 2'b01, 1, 8'h40, 8'h40, 32'h0,     8'h00, 0, 0, 1);
        add(0, 2'b00, 0, 8'h00, 8'h41, 32'h140,   8'h40, 1, 0, 1);
        add(0, 2'b01, 1, 8'h04, 8'h04, 32'h0,     8'h00, 0, 0, 2);
        add(0, 2'b00, 0, 8'h00, 8'h05, 32'h104,   8'h04, 1, 0, 2);
        add(0, 2'b10, 0, 8'h00, 8'h05, 32'h104,   8'h04, 1, 1, 2);
        add(0, 2'b10, 0, 8'h00, 8'h05, 32'h104,   8'h04, 1, 2, 2);
        add(0, 2'b00, 0, 8'h00, 8'h06, 32'h105,   8'h05, 1, 2, 2);
        add(0, 2'b01, 1, 8'hFF, 8'hFF, 32'h0,     8'h00, 0, 2, 3);
        add(0, 2'b00, 0, 8'h00, 8'h00, 32'h1FF,   8'hFF, 1, 2, 3);
        add(0, 2'b00, 0, 8'h00, 8'h01, 32'h100,   8'h00, 1, 2, 3);
        add(0, 2'b11, 0, 8'h00, 8'h01, 32'h100,   8'h00, 1, 3, 3);
        add(0, 2'b11, 0, 8'h00, 8'h01, 32'h100,   8'h00, 1, 4, 3);
        add(0, 2'b11, 0, 8'h00, 8'h01, 32'h100,   8'h00, 1, 5, 3);
        add(0, 2'b00, 0, 8'h00, 8'h02, 32'h101,   8'h01, 1, 5, 3);
        add(0, 2'b01, 0, 8'h00, 8'h03, 32'h0,     8'h00, 0, 5, 4);
        add(1, 2'b10, 1, 8'h40, 8'h00, 32'h0,     8'h00, 0, 0, 0);
        add(0, 2'b00, 0, 8'h00, 8'h01, 32'h100,   8'h00, 1, 0, 0);
        add(0, 2'b01, 0, 8'h00, 8'h02, 32'h0,     8'h00, 0, 0, 1);
        add(0, 2'b10, 0, 8'h00, 8'h02, 32'h0,     8'h00, 0, 1, 1);
        add(0, 2'b00, 0, 8'h00, 8'h03, 32'h102,   8'h02, 1, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; mux = vecs[i].mux;
            taken = vecs[i].taken; target = vecs[i].target;
            @(posedge clk);
            #1;
            check("addr",  i, {24'h0, addr},      {24'h0, vecs[i].exp_addr});
            check("instr", i, instr_id,           vecs[i].exp_instr);
            check("pc_id", i, {24'h0, pc_id},     {24'h0, vecs[i].exp_pc_id});
            check("valid", i, {31'h0, valid_id},  {31'h0, vecs[i].exp_valid});
            check("stall", i, {16'h0, stall_cnt}, {16'h0, vecs[i].exp_stall});
            check("flush", i, {16'h0, flush_cnt}, {16'h0, vecs[i].exp_flush});
        end

        // Synchronous reset: nothing moves before the edge.
        @(negedge clk);
        rst = 1'b1; mux = 2'b00; taken = 1'b0;
        #1;
        check("sync_rst_addr",  100, {24'h0, addr},     32'h03);
        check("sync_rst_valid", 100, {31'h0, valid_id}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_edge_addr",  101, {24'h0, addr},     32'h00);
        check("rst_edge_valid", 101, {31'h0, valid_id}, 32'h0);

        // Saturation on the narrow-counter instance.
        @(negedge clk);
        rst2 = 1'b1; mux2 = 2'b00;
        @(posedge clk);
        #1;
        check("sat_reset", 200, {28'h0, stall_cnt2}, 32'h0);
        @(negedge clk);
        rst2 = 1'b0; mux2 = 2'b10;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (c == 14 || c == 15 || c == 16 || c == 20)
                check("sat_stall", 200 + c, {28'h0, stall_cnt2}, (c < 15) ? c : 15);
        end
        check("sat_addr",  221, {24'h0, addr2},      32'h00);
        check("sat_flush", 222, {28'h0, flush_cnt2}, 32'h0);
        check("sat_valid", 223, {31'h0, valid_id2},  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage core: owns the program counter and the IF/ID pipeline register. It sits directly downstream of the hazard/pipeline-management unit, whose `MUX_IF_PM` (normal / NOP / freeze) and `Is_Address_Taken` outputs it consumes. It also sits upstream of the ID stage, which it feeds with `Instr_ID`, `PC_ID` and `Valid_ID`. It additionally keeps saturating stall and flush event counters for performance debug.

## Interface
- `PC_WIDTH`, 8: program counter width; word-addressed, so one increment is one instruction.
- `INSTR_WIDTH`, 32: instruction width.
- `RESET_PC`, 0: PC value after reset.
- `NOP_INSTR`, 0: encoding inserted into IF/ID on flush and reset.
- `CNT_WIDTH`, 16: width of each event counter.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `MUX_IF_PM` input 2: IF/ID control.
  - 00 normal.
  - 01 NOP (flush).
  - 10 freeze.
  - 11 is treated as freeze.
- `Is_Address_Taken` input 1: redirect request; PC loads `Branch_Target`.
- `Branch_Target` input PC_WIDTH: redirect address.
- `Instr_Mem_Addr` output PC_WIDTH: current PC, driven to the asynchronous-read instruction memory.
- `Instr_Mem_Data` input INSTR_WIDTH: instruction at `Instr_Mem_Addr`, valid in the same cycle.
- `Instr_ID` output INSTR_WIDTH: IF/ID instruction.
- `PC_ID` output PC_WIDTH: IF/ID PC of `Instr_ID`.
- `Valid_ID` output 1: IF/ID holds a real fetched instruction, not a bubble.
- `Stall_Count` output CNT_WIDTH: count of freeze cycles.
- `Flush_Count` output CNT_WIDTH: count of flush cycles.

## Operation
- `Instr_Mem_Addr` is the PC register, with no combinational path from the inputs.

PC next-value priority:
1. `rst` loads `RESET_PC`.
2. `Is_Address_Taken` loads `Branch_Target`.
3. `MUX_IF_PM` of 10 or 11 holds the PC.
4. Otherwise the PC becomes PC+1 modulo 2^PC_WIDTH. All-ones wraps to 0 with no flag.

IF/ID register priority:
1. `rst` loads `Instr_ID`=`NOP_INSTR`, `PC_ID`=0, `Valid_ID`=0.
2. `MUX_IF_PM` 01 loads `Instr_ID`=`NOP_INSTR`, `PC_ID`=0, `Valid_ID`=0.
3. `MUX_IF_PM` 10 or 11 holds all three fields.
4. `MUX_IF_PM` 00 loads `Instr_ID`=`Instr_Mem_Data`, `PC_ID`=current PC, `Valid_ID`=1.

Coupling rules:
- The PC follows `Is_Address_Taken`; the IF/ID register follows `MUX_IF_PM`.
- The hazard unit guarantees `Is_Address_Taken`=1 implies `MUX_IF_PM`=01. The block does not cross-check this.
- `MUX_IF_PM`=01 with `Is_Address_Taken`=0 flushes IF/ID while the PC advances normally.

Counters:
- `Stall_Count` increments on each non-reset cycle with `MUX_IF_PM` in {10, 11}.
- `Flush_Count` increments on each non-reset cycle with `MUX_IF_PM`=01.
- Both saturate at 2^CNT_WIDTH−1.
- Both clear only on `rst`.

Reset values: `Instr_Mem_Addr`=`RESET_PC`, `Instr_ID`=`NOP_INSTR`, `PC_ID`=0, `Valid_ID`=0, `Stall_Count`=0, `Flush_Count`=0.

## Timing
- PC-to-IF/ID latency is 1 cycle. An instruction presented on `Instr_Mem_Data` in cycle n appears on `Instr_ID` in cycle n+1 when `MUX_IF_PM`=00.
- First cycle after reset deasserts: fetch from `RESET_PC`. The next cycle `Instr_ID`=mem[RESET_PC] and `Valid_ID`=1.
- Redirect when `Is_Address_Taken` is sampled in cycle n:
  - `Instr_ID` is a bubble in n+1.
  - `Instr_Mem_Addr`=`Branch_Target` in n+1.
  - The target instruction reaches `Instr_ID` in n+2, provided `MUX_IF_PM`=00 in n+1.
- Freeze for k consecutive cycles: PC and IF/ID are unchanged for those k edges, and fetching resumes on the first 00 cycle.
- Freeze is a hold, not a bubble: `Valid_ID` is unchanged during freeze.
- `rst` asserted mid-redirect or mid-freeze: reset wins on that edge, and the counters do not count that cycle.
- `rst` is synchronous: it takes effect only on a clock edge, and outputs keep their old values until that edge.

## Test plan
- Reset then free run, with mem[i]=32'h100+i:
  - After `rst` drops, `Instr_ID` sequence is 32'h100, 101, 102.
  - `PC_ID` sequence is 0, 1, 2.
  - `Valid_ID`=1 from the first post-reset edge onward.
- Load-use stall, with `MUX_IF_PM`=10 for 2 cycles at PC=5:
  - `Instr_Mem_Addr` stays 5 for those 2 cycles.
  - `Instr_ID` holds mem[4].
  - `Stall_Count`=2.
  - Next `Instr_ID` is mem[5].
- Taken branch, with `Is_Address_Taken`=1, `MUX_IF_PM`=01 and `Branch_Target`=8'h40 at PC=3:
  - Next cycle: `Instr_ID`=`NOP_INSTR`, `Valid_ID`=0, `Instr_Mem_Addr`=8'h40.
  - Cycle after: `Instr_ID`=mem[0x40] and `PC_ID`=8'h40.
  - `Flush_Count`=1.
- PC wrap:
  - Force a redirect to 8'hFF and run free.
  - `PC_ID` sequence is FF then 00, with no hang.
- Simultaneous events:
  - `rst`=1 together with `Is_Address_Taken`=1: PC returns to `RESET_PC`, and both counters are 0.
  - `MUX_IF_PM`=11 for 3 cycles: behaves as freeze, and `Stall_Count` reaches 3.
- Counter saturation, with `CNT_WIDTH`=4:
  - Hold `MUX_IF_PM`=10 for 20 cycles.
  - `Stall_Count` stops at 15 and does not wrap.
